// File: rtl/lapido_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lapido_pkg
// Description : Shared definitions for the pipeline hazard controller:
//               FSM state encoding, default register-index width, default
//               memory-wait timeout and a helper that sizes the wait counter.
// Revision    : 1.0  initial release
// ============================================================================
package lapido_pkg;

    // Hazard controller FSM states
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ERROR = 2'd3
    } hazard_state_t;

    // Register-index width, matches the 4-bit registerFileWrite field
    localparam int REG_BITS_DEF    = 4;
    // Maximum consecutive memBusy cycles tolerated before ERROR
    localparam int MEM_TIMEOUT_DEF = 255;

    // Width needed to hold the values 0..timeout in the wait counter
    function automatic int wait_cnt_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage : lapido_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter. Advances on the falling clock edge
//               (aligned with the pipeline registers) and sticks at all-ones.
// Ports       : clock    in   clock (falling edge active)
//               clear_n  in   asynchronous active-low clear
//               inc      in   increment enable
//               count    out  WIDTH-bit count value
// Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(negedge clock or negedge clear_n) begin
        if (!clear_n) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller. Detects load-use hazards, flushes
//               on taken branches, freezes the front end while data memory is
//               busy and latches a sticky timeout error when memory stays busy
//               for MEM_TIMEOUT consecutive cycles. State updates on the
//               falling clock edge, aligned with the pipeline registers.
// Config      : HAZARD_PERF_EN - when defined, stallCount / flushCount are
//               live saturating counters; otherwise they are tied to zero.
// Ports       : clock                  in   clock (falling edge active)
//               reset_n                in   asynchronous active-low reset
//               ifidRs, ifidRt         in   decode-stage source registers
//               ifidUsesRt             in   decode instruction reads ifidRt
//               idexMemRead            in   ID/EX holds a load
//               idexRegWrite           in   ID/EX writes a register
//               idexRegisterFileWrite  in   ID/EX destination register
//               exBranchTaken          in   branch resolved taken in EX
//               memBusy                in   data memory not ready
//               pcWrite, ifidWrite     out  PC / IF/ID update enables
//               idexBubble             out  zero all ID/EX control inputs
//               idexHold               out  ID/EX keeps its contents
//               ifidFlush              out  zero the IF/ID instruction
//               memTimeout             out  sticky memory-timeout error
//               stallCount, flushCount out  performance counters
// Revision    : 1.0  initial release
// ============================================================================
module hazard_ctrl
    import lapido_pkg::*;
#(
    parameter int REG_BITS    = REG_BITS_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [REG_BITS-1:0] ifidRs,
    input  logic [REG_BITS-1:0] ifidRt,
    input  logic                ifidUsesRt,
    input  logic                idexMemRead,
    input  logic                idexRegWrite,
    input  logic [REG_BITS-1:0] idexRegisterFileWrite,
    input  logic                exBranchTaken,
    input  logic                memBusy,
    output logic                pcWrite,
    output logic                ifidWrite,
    output logic                idexBubble,
    output logic                idexHold,
    output logic                ifidFlush,
    output logic                memTimeout,
    output logic [CNT_W-1:0]    stallCount,
    output logic [CNT_W-1:0]    flushCount
);

    localparam int WAIT_W = wait_cnt_width(MEM_TIMEOUT);

    hazard_state_t     state;
    hazard_state_t     state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    logic [WAIT_W-1:0] wait_cnt_inc;
    logic              load_use;
    logic              stall_inc;
    logic              flush_inc;

    // Register 0 is deliberately not exempt from the hazard compare.
    assign load_use = idexMemRead & idexRegWrite &
                      ((idexRegisterFileWrite == ifidRs) |
                       (ifidUsesRt & (idexRegisterFileWrite == ifidRt)));

    assign wait_cnt_inc = wait_cnt + WAIT_W'(1);

    // ERROR is only left through reset, so the state itself is the sticky flag.
    assign memTimeout = (state == ST_ERROR);

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        pcWrite      = 1'b1;
        ifidWrite    = 1'b1;
        idexBubble   = 1'b0;
        idexHold     = 1'b0;
        ifidFlush    = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;

        case (state)
            ST_RUN, ST_STALL: begin
                // Priority: branch > memBusy > loadUse. A loadUse still
                // present during the STALL cycle is the one already handled.
                if (exBranchTaken) begin
                    ifidFlush = 1'b1;
                    idexBubble = 1'b1;
                    flush_inc = 1'b1;
                    state_nxt = ST_RUN;
                end else if (memBusy) begin
                    pcWrite      = 1'b0;
                    ifidWrite    = 1'b0;
                    idexHold     = 1'b1;
                    stall_inc    = 1'b1;
                    wait_cnt_nxt = WAIT_W'(1);
                    state_nxt    = (MEM_TIMEOUT <= 1) ? ST_ERROR : ST_WAIT;
                end else if (load_use && (state == ST_RUN)) begin
                    pcWrite    = 1'b0;
                    ifidWrite  = 1'b0;
                    idexBubble = 1'b1;
                    stall_inc  = 1'b1;
                    state_nxt  = ST_STALL;
                end else begin
                    state_nxt = ST_RUN;
                end
            end

            ST_WAIT: begin
                // A branch sitting in EX is frozen with the pipeline and is
                // acted on once memory releases.
                if (memBusy) begin
                    pcWrite      = 1'b0;
                    ifidWrite    = 1'b0;
                    idexHold     = 1'b1;
                    stall_inc    = 1'b1;
                    wait_cnt_nxt = wait_cnt_inc;
                    if (wait_cnt_inc >= WAIT_W'(MEM_TIMEOUT)) begin
                        state_nxt = ST_ERROR;
                    end
                end else begin
                    wait_cnt_nxt = '0;
                    state_nxt    = ST_RUN;
                end
            end

            ST_ERROR: begin
                pcWrite   = 1'b0;
                ifidWrite = 1'b0;
                idexHold  = 1'b1;
            end

            default: begin
                state_nxt = ST_RUN;
            end
        endcase

        // While reset is held the pipeline must run free, even if a freeze
        // condition is present on the inputs.
        if (!reset_n) begin
            pcWrite    = 1'b1;
            ifidWrite  = 1'b1;
            idexBubble = 1'b0;
            idexHold   = 1'b0;
            ifidFlush  = 1'b0;
        end
    end

`ifdef HAZARD_PERF_EN
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clock   (clock),
        .clear_n (reset_n),
        .inc     (stall_inc),
        .count   (stallCount)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clock   (clock),
        .clear_n (reset_n),
        .inc     (flush_inc),
        .count   (flushCount)
    );
`else
    assign stallCount = '0;
    assign flushCount = '0;

    logic unused_perf;
    assign unused_perf = stall_inc ^ flush_inc;
`endif

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. Directed scenarios and a
//               randomized run, all compared against a behavioural model that
//               tracks "busy run length", "just stalled" and "errored" as plain
//               integers and flags.
// Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int TO = 6;
    localparam int CW = 4;
`ifdef HAZARD_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [3:0]    ifidRs = '0, ifidRt = '0, idexRegisterFileWrite = '0;
    logic          ifidUsesRt = 1'b0, idexMemRead = 1'b0, idexRegWrite = 1'b0;
    logic          exBranchTaken = 1'b0, memBusy = 1'b0;
    logic          pcWrite, ifidWrite, idexBubble, idexHold, ifidFlush, memTimeout;
    logic [CW-1:0] stallCount, flushCount;
    logic [5:0]    outs;

    int n_pass = 0;
    int n_total = 0;

    // Reference model state
    int         m_busy_run;
    bit         m_after_stall;
    bit         m_error;
    int         m_stalls;
    int         m_flushes;
    logic [5:0] e_outs;
    logic [CW-1:0] e_stall, e_flush;

    hazard_ctrl #(
        .REG_BITS    (4),
        .MEM_TIMEOUT (TO),
        .CNT_W       (CW)
    ) dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .ifidRs                (ifidRs),
        .ifidRt                (ifidRt),
        .ifidUsesRt            (ifidUsesRt),
        .idexMemRead           (idexMemRead),
        .idexRegWrite          (idexRegWrite),
        .idexRegisterFileWrite (idexRegisterFileWrite),
        .exBranchTaken         (exBranchTaken),
        .memBusy               (memBusy),
        .pcWrite               (pcWrite),
        .ifidWrite             (ifidWrite),
        .idexBubble            (idexBubble),
        .idexHold              (idexHold),
        .ifidFlush             (ifidFlush),
        .memTimeout            (memTimeout),
        .stallCount            (stallCount),
        .flushCount            (flushCount)
    );

    // {pcWrite, ifidWrite, idexBubble, idexHold, ifidFlush, memTimeout}
    assign outs = {pcWrite, ifidWrite, idexBubble, idexHold, ifidFlush, memTimeout};

    always #5 clock = ~clock;

    function automatic int sat(input int v);
        int mx;
        mx = (1 << CW) - 1;
        if (!PERF_ON) return 0;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_busy_run = 0; m_after_stall = 0; m_error = 0;
        m_stalls = 0; m_flushes = 0;
    endtask

    // One cycle of the behavioural model. Counter expectations are the values
    // visible before this cycle's falling edge.
    task automatic model_step(input bit br, input bit mb, input bit lu);
        e_stall = CW'(sat(m_stalls));
        e_flush = CW'(sat(m_flushes));
        if (m_error) begin
            e_outs = 6'b000101;
        end else if (m_busy_run > 0) begin
            if (mb) begin
                e_outs = 6'b000100;
                m_busy_run++; m_stalls++;
                if (m_busy_run >= TO) m_error = 1;
            end else begin
                e_outs = 6'b110000;
                m_busy_run = 0;
            end
        end else if (br) begin
            e_outs = 6'b111010; m_flushes++; m_after_stall = 0;
        end else if (mb) begin
            e_outs = 6'b000100; m_busy_run = 1; m_stalls++; m_after_stall = 0;
            if (TO <= 1) m_error = 1;
        end else if (lu && !m_after_stall) begin
            e_outs = 6'b001000; m_stalls++; m_after_stall = 1;
        end else begin
            e_outs = 6'b110000; m_after_stall = 0;
        end
    endtask

    // Drive one cycle of inputs after the rising edge and step the model.
    task automatic tick(input bit br, input bit mb, input bit mr, input bit rw,
                        input logic [3:0] dst, input logic [3:0] rs,
                        input logic [3:0] rt, input bit ut);
        bit lu;
        @(posedge clock);
        exBranchTaken = br; memBusy = mb; idexMemRead = mr; idexRegWrite = rw;
        idexRegisterFileWrite = dst; ifidRs = rs; ifidRt = rt; ifidUsesRt = ut;
        #1;
        lu = mr && rw && ((dst == rs) || (ut && (dst == rt)));
        model_step(br, mb, lu);
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 4'd2, 1'b0);
    endtask

    task automatic apply_reset();
        @(posedge clock);
        reset_n = 1'b0;
        exBranchTaken = 1'b0; memBusy = 1'b0; idexMemRead = 1'b0; idexRegWrite = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clock);
        reset_n = 1'b0;
        memBusy = 1'b1; idexMemRead = 1'b1; idexRegWrite = 1'b1;
        idexRegisterFileWrite = 4'd5; ifidRs = 4'd5;
        @(negedge clock); #1;
        n_total++;
        if (outs !== 6'b110000) $display("FAIL reset_outs got=%b exp=110000", outs);
        else n_pass++;
        n_total++;
        if (stallCount !== '0 || flushCount !== '0)
            $display("FAIL reset_counters got=%0d/%0d exp=0/0", stallCount, flushCount);
        else n_pass++;
        apply_reset();
    endtask

    task automatic test_load_use();
        apply_reset();
        tick(1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 4'd3, 4'd7, 1'b0);
        n_total++;
        if (outs !== e_outs || pcWrite !== 1'b0 || idexBubble !== 1'b1)
            $display("FAIL lu_detect got=%b exp=%b", outs, e_outs);
        else n_pass++;
        tick(1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 4'd3, 4'd7, 1'b0);
        n_total++;
        if (outs !== e_outs || outs !== 6'b110000)
            $display("FAIL lu_stall_cycle got=%b exp=%b", outs, e_outs);
        else n_pass++;
        idle();
        n_total++;
        if (outs !== 6'b110000 || stallCount !== CW'(PERF_ON ? 1 : 0))
            $display("FAIL lu_count got=%b/%0d exp=110000/%0d", outs, stallCount, PERF_ON ? 1 : 0);
        else n_pass++;
        // Register 0 via Rt must still be treated as a hazard
        tick(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd9, 4'd0, 1'b1);
        n_total++;
        if (outs !== e_outs || outs !== 6'b001000)
            $display("FAIL lu_reg0_rt got=%b exp=%b", outs, e_outs);
        else n_pass++;
        idle();
    endtask

    task automatic test_branch();
        apply_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 4'd2, 1'b0);
        n_total++;
        if (outs !== e_outs || ifidFlush !== 1'b1 || idexBubble !== 1'b1)
            $display("FAIL br_flush got=%b exp=%b", outs, e_outs);
        else n_pass++;
        idle();
        n_total++;
        if (ifidFlush !== 1'b0 || flushCount !== CW'(PERF_ON ? 1 : 0))
            $display("FAIL br_once got=%b/%0d exp=0/%0d", ifidFlush, flushCount, PERF_ON ? 1 : 0);
        else n_pass++;
    endtask

    task automatic test_mem_wait();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 4'd2, 1'b0);
            n_total++;
            if (outs !== e_outs || pcWrite !== 1'b0 || idexHold !== 1'b1)
                $display("FAIL mw_freeze_%0d got=%b exp=%b", i, outs, e_outs);
            else n_pass++;
        end
        idle();
        n_total++;
        if (outs !== 6'b110000) $display("FAIL mw_release got=%b exp=110000", outs);
        else n_pass++;
        idle();
        n_total++;
        if (stallCount !== CW'(PERF_ON ? 5 : 0))
            $display("FAIL mw_count got=%0d exp=%0d", stallCount, PERF_ON ? 5 : 0);
        else n_pass++;
    endtask

    task automatic test_priority();
        apply_reset();
        tick(1'b1, 1'b1, 1'b1, 1'b1, 4'd4, 4'd4, 4'd4, 1'b1);
        n_total++;
        if (outs !== 6'b111010 || outs !== e_outs)
            $display("FAIL prio_flush got=%b exp=111010", outs);
        else n_pass++;
        idle();
        n_total++;
        if (outs !== 6'b110000) $display("FAIL prio_next_run got=%b exp=110000", outs);
        else n_pass++;
    endtask

    task automatic test_timeout();
        apply_reset();
        for (int i = 0; i < TO; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 4'd2, 1'b0);
            n_total++;
            if (outs !== e_outs || memTimeout !== 1'b0)
                $display("FAIL to_busy_%0d got=%b exp=%b", i, outs, e_outs);
            else n_pass++;
        end
        idle();
        n_total++;
        if (outs !== 6'b000101 || outs !== e_outs)
            $display("FAIL to_error got=%b exp=000101", outs);
        else n_pass++;
        idle();
        n_total++;
        if (memTimeout !== 1'b1) $display("FAIL to_sticky got=%b exp=1", memTimeout);
        else n_pass++;
        // Asynchronous clear well away from any falling edge
        #1 reset_n = 1'b0;
        #1;
        n_total++;
        if (memTimeout !== 1'b0 || pcWrite !== 1'b1 || ifidWrite !== 1'b1)
            $display("FAIL to_async_clear got=%b exp=110000", outs);
        else n_pass++;
        apply_reset();
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b1, 4'd6, 4'd6, 4'd0, 1'b0);
            idle();
        end
        idle();
        n_total++;
        if (stallCount !== (PERF_ON ? 4'd15 : 4'd0) || stallCount !== e_stall)
            $display("FAIL sat_stall got=%0d exp=%0d", stallCount, PERF_ON ? 15 : 0);
        else n_pass++;
    endtask

    task automatic test_random();
        bit br, mb, mr, rw, ut;
        logic [3:0] dst, rs, rt;
        mb = 0;
        apply_reset();
        for (int i = 0; i < 500; i++) begin
            if (m_error && ($urandom_range(0, 3) == 0)) apply_reset();
            br  = ($urandom_range(0, 7) == 0);
            mb  = mb ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
            mr  = $urandom_range(0, 1);
            rw  = ($urandom_range(0, 3) != 0);
            ut  = $urandom_range(0, 1);
            dst = 4'($urandom_range(0, 3));
            rs  = 4'($urandom_range(0, 3));
            rt  = 4'($urandom_range(0, 3));
            tick(br, mb, mr, rw, dst, rs, rt, ut);
            n_total++;
            if (outs !== e_outs || stallCount !== e_stall || flushCount !== e_flush)
                $display("FAIL rand_%0d got=%b/%0d/%0d exp=%b/%0d/%0d", i, outs,
                         stallCount, flushCount, e_outs, e_stall, e_flush);
            else n_pass++;
            n_total++;
            if ((idexBubble && idexHold) || (ifidFlush && !ifidWrite))
                $display("FAIL rand_invariant_%0d got=%b", i, outs);
            else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_priority();
        test_timeout();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_hazard_ctrl
`default_nettype wire
